encoder4to2_rr: RTL and testbench

//   Registered N-to-log2(N) encoder: the encode-side counterpart of the 2-to-4 line decoder.

---
 rtl/encoder4to2_rr.sv | 82 ++++++++
 tb/tb_encoder4to2_rr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder4to2_rr.sv
// Registered priority encoder (fixed or round-robin) with zero/multi-hot flags; latency 1 cycle.
// Ready/valid on both sides; full throughput; results are held stable while out_ready is low.
module encoder4to2_rr #(
  parameter int N    = 4,
  parameter int W    = 2,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_multi,
  output logic [7:0]   err_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         zero;
    logic         multi;
  } res_t;

  state_t       state;
  res_t         res_q;
  res_t         res_d;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] cand;
  logic         found;
  logic         accept;
  logic         consume;

  assign in_ready  = rst_n & ((state == EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = (state == FULL) & out_ready;
  assign out_valid = (state == FULL);
  assign out_idx   = res_q.idx;
  assign out_zero  = res_q.zero;
  assign out_multi = res_q.multi;

  // Scan N positions starting at rr_ptr; W-bit addition gives the wrap for free.
  always_comb begin
    res_d = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = (MODE == 1) ? rr_ptr + W'(i) : W'(i);
      if (!found && in_vec[cand]) begin
        res_d.idx = cand;
        found     = 1'b1;
      end
    end
    res_d.zero  = ~|in_vec;
    res_d.multi = |(in_vec & (in_vec - N'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      res_q   <= '0;
      rr_ptr  <= '0;
      err_cnt <= '0;
    end else begin
      if (accept) begin
        state <= FULL;
        res_q <= res_d;
        if (MODE == 1 && found)
          rr_ptr <= res_d.idx + W'(1);
        if (res_d.multi && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end else if (consume) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_encoder4to2_rr.sv
// Bench for encoder4to2_rr: a fixed-priority and a round-robin instance share one input stream
// and are compared against a behavioural model plus directed expectations.
module tb_encoder4to2_rr;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] in_vec;
  logic       rdy0, rdy1, ov0, ov1, z0, z1, mu0, mu1;
  logic [1:0] idx0, idx1;
  logic [7:0] err0, err1;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_valid;
  int m_idx [2];
  bit m_zero, m_multi;
  int m_ptr;
  int m_err;

  encoder4to2_rr #(.N(4), .W(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_vec(in_vec),
    .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0), .out_zero(z0),
    .out_multi(mu0), .err_cnt(err0)
  );

  encoder4to2_rr #(.N(4), .W(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_vec(in_vec),
    .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1), .out_zero(z1),
    .out_multi(mu1), .err_cnt(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_winner(input int mode, input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (mode == 1) ? (ptr + k) % 4 : k;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  function automatic bit model_ready();
    return (rst_n === 1'b1) && (!m_valid || out_ready === 1'b1);
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUTs.
  task automatic tick();
    bit acc;
    acc = (in_valid === 1'b1) && model_ready();
    if (rst_n !== 1'b1) begin
      m_valid = 0; m_idx[0] = 0; m_idx[1] = 0; m_zero = 0; m_multi = 0; m_ptr = 0; m_err = 0;
    end else if (acc) begin
      m_valid  = 1;
      m_idx[0] = ref_winner(0, in_vec, 0);
      m_idx[1] = ref_winner(1, in_vec, m_ptr);
      m_zero   = (in_vec == 4'b0000);
      m_multi  = ($countones(in_vec) > 1);
      if (in_vec != 4'b0000) m_ptr = (m_idx[1] + 1) % 4;
      if (m_multi && m_err < 255) m_err = m_err + 1;
    end else if (m_valid && out_ready === 1'b1) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_vec = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_vec = 4'b1111;
    #1;
    checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready got=%b/%b exp=0", rdy0, rdy1); end
    tick(); tick();
    checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got=%b/%b exp=0", ov0, ov1); end
    checks++; if (idx0 !== 2'd0 || z0 !== 1'b0 || mu0 !== 1'b0) begin errors++;
      $display("FAIL reset_fields got idx=%0d zero=%b multi=%b exp 0/0/0", idx0, z0, mu0); end
    checks++; if (err0 !== 8'd0 || err1 !== 8'd0) begin errors++;
      $display("FAIL reset_err_cnt got=%0d/%0d exp=0", err0, err1); end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_onehot_sweep();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_vec = 4'(1 << i);
      #1;
      checks++; if (rdy0 !== 1'b1) begin errors++;
        $display("FAIL sweep_in_ready[%0d] got=%b exp=1", i, rdy0); end
      tick();
      checks++; if (ov0 !== 1'b1 || idx0 !== 2'(i) || mu0 !== 1'b0) begin errors++;
        $display("FAIL sweep_idx[%0d] got v=%b idx=%0d multi=%b exp v=1 idx=%0d multi=0",
                 i, ov0, idx0, mu0, i); end
      checks++; if (idx1 !== 2'(m_idx[1])) begin errors++;
        $display("FAIL sweep_rr_idx[%0d] got=%0d exp=%0d", i, idx1, m_idx[1]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (ov0 !== 1'b0) begin errors++;
      $display("FAIL sweep_drain got=%b exp=0", ov0); end
  endtask

  task automatic test_multi_zero();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'b0110;
    tick();
    checks++; if (idx0 !== 2'd1 || mu0 !== 1'b1 || z0 !== 1'b0 || err0 !== 8'd1) begin errors++;
      $display("FAIL multi_0110 got idx=%0d multi=%b zero=%b err=%0d exp 1/1/0/1",
               idx0, mu0, z0, err0); end
    in_vec = 4'b0000;
    tick();
    checks++; if (ov0 !== 1'b1 || idx0 !== 2'd0 || z0 !== 1'b1 || mu0 !== 1'b0) begin errors++;
      $display("FAIL zero_vec got v=%b idx=%0d zero=%b multi=%b exp 1/0/1/0", ov0, idx0, z0, mu0); end
    checks++; if (idx1 !== 2'd0 || z1 !== 1'b1 || err1 !== 8'd1) begin errors++;
      $display("FAIL zero_vec_rr got idx=%0d zero=%b err=%0d exp 0/1/1", idx1, z1, err1); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rr();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (idx1 !== 2'(k % 4) || idx0 !== 2'd0) begin errors++;
        $display("FAIL rr_idx[%0d] got rr=%0d fixed=%0d exp rr=%0d fixed=0", k, idx1, idx0, k % 4); end
    end
    checks++; if (err1 !== 8'd5) begin errors++;
      $display("FAIL rr_err_cnt got=%0d exp=5", err1); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'b0100;
    tick();
    out_ready = 1'b0; in_vec = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rdy0 !== 1'b0) begin errors++;
        $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, rdy0); end
      tick();
      checks++; if (ov0 !== 1'b1 || idx0 !== 2'd2 || idx1 !== 2'd2) begin errors++;
        $display("FAIL bp_hold[%0d] got v=%b idx=%0d/%0d exp v=1 idx=2", k, ov0, idx0, idx1); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++;
      $display("FAIL bp_release_ready got=%b exp=1", rdy0); end
    tick();
    checks++; if (ov0 !== 1'b1 || idx0 !== 2'd3 || idx1 !== 2'd3) begin errors++;
      $display("FAIL bp_replace got v=%b idx=%0d/%0d exp v=1 idx=3", ov0, idx0, idx1); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'b0110;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (err1 !== 8'd7 || m_ptr != 2 || ov1 !== 1'b1) begin errors++;
      $display("FAIL midop_setup got err=%0d v=%b model_ptr=%0d exp err=7 v=1 ptr=2", err1, ov1, m_ptr); end
    out_ready = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++;
      $display("FAIL midop_in_ready got=%b/%b exp=0", rdy0, rdy1); end
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (ov1 !== 1'b0 || err1 !== 8'd0 || ov0 !== 1'b0 || err0 !== 8'd0) begin errors++;
      $display("FAIL midop_cleared got v=%b err=%0d exp v=0 err=0", ov1, err1); end
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'b1111;
    tick();
    checks++; if (idx1 !== 2'd0) begin errors++;
      $display("FAIL midop_ptr_cleared got=%0d exp=0", idx1); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 301; k++) begin
      do in_vec = 4'($urandom_range(0, 15)); while ($countones(in_vec) < 2);
      tick();
      checks++; if (err0 !== 8'(m_err) || idx1 !== 2'(m_idx[1]) || mu1 !== 1'b1) begin errors++;
        $display("FAIL sat_step[%0d] got err=%0d rr=%0d exp err=%0d rr=%0d", k, err0, idx1, m_err, m_idx[1]); end
      if (k == 299) begin
        checks++; if (err0 !== 8'hFF || err1 !== 8'hFF) begin errors++;
          $display("FAIL sat_300 got=%0d/%0d exp=255", err0, err1); end
      end
    end
    checks++; if (err0 !== 8'hFF || err1 !== 8'hFF) begin errors++;
      $display("FAIL sat_hold got=%0d/%0d exp=255", err0, err1); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      in_vec    = 4'($urandom_range(0, 15));
      #1;
      checks++; if (rdy0 !== 1'(model_ready()) || rdy1 !== rdy0) begin errors++;
        $display("FAIL rand_in_ready[%0d] got=%b/%b exp=%b", k, rdy0, rdy1, model_ready()); end
      tick();
      checks++;
      if (ov0 !== 1'(m_valid) || ov1 !== 1'(m_valid) || idx0 !== 2'(m_idx[0]) ||
          idx1 !== 2'(m_idx[1]) || z0 !== 1'(m_zero) || z1 !== 1'(m_zero) ||
          mu0 !== 1'(m_multi) || mu1 !== 1'(m_multi) || err0 !== 8'(m_err) || err1 !== 8'(m_err)) begin
        errors++;
        $display("FAIL rand_out[%0d] got v=%b idx=%0d/%0d z=%b m=%b err=%0d exp v=%b idx=%0d/%0d z=%b m=%b err=%0d",
                 k, ov0, idx0, idx1, z0, mu0, err0, m_valid, m_idx[0], m_idx[1], m_zero, m_multi, m_err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = 4'b0000;
    m_valid = 0; m_idx[0] = 0; m_idx[1] = 0; m_zero = 0; m_multi = 0; m_ptr = 0; m_err = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_onehot_sweep();
    test_multi_zero();
    test_rr();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
